pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32IMF pipeline. It watches the decoded instruction in ID, the instruction in EX and the branch outcome from EX. It drives the IF/ID and ID/EX pipeline-register controls that resolve three cases: load-use hazards, multi-cycle MUL/DIV occupancy of EX, and taken-branch flushes. Forwarding-mux selection stays in decode; this block covers only the cases forwarding cannot resolve.

Parameters:
DIV_LAT, 32, EX cycles occupied by DIV/DIVU/REM/REMU (>=1)
MUL_LAT, 1, EX cycles occupied by MUL/MULH/MULHSU/MULHU (>=1)
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
ID_vld  in  1  decoded instruction in ID is valid
ID_rs1  in  6  ID source 1 ({fp_bank, idx}); 6'h00 = zero reg
ID_rs2  in  6  ID source 2, same encoding
ID_alu_func  in  5  ID ALU function code (shared ALU_* encoding)
ID_EX_rd  in  6  destination of instruction currently in EX
ID_EX_is_load  in  1  instruction in EX is a load (integer or FP)
ID_EX_vld  in  1  instruction in EX is valid
EX_br_taken  in  1  EX resolved a taken branch or jump this cycle
stall_if  out  1  hold PC and IF/ID register
stall_id  out  1  hold ID stage (IF/ID not updated)
bubble_ex  out  1  load a NOP (vld=0) into ID/EX
hold_ex  out  1  hold ID/EX register and EX operands (multi-cycle op)
bubble_mem  out  1  load a NOP into EX/MEM
flush_if_id  out  1  invalidate IF/ID contents
mc_busy  out  1  multi-cycle op occupying EX
stall_cycles  out  CNT_W  count of cycles with stall_if=1

Behaviour:
- Reset (rst=1 at a posedge): state <= RUN, busy counter <= 0, stall_cycles <= 0. While rst is high, all control outputs are forced to 0.
- States: RUN, MC_BUSY.
- Zero register is exactly 6'h00. 6'h20 (f0) is a real register. All 6 bits are compared.
- Load-use, RUN only. Condition: ID_vld & ID_EX_vld & ID_EX_is_load & ID_EX_rd!=0 & (ID_rs1==ID_EX_rd | ID_rs2==ID_EX_rd).
  - Response: stall_if=stall_id=bubble_ex=1 for that cycle, combinationally.
  - Next cycle the load is in MEM and the hazard clears by itself. Exactly 1 stall cycle per load-use pair.
- Branch flush, RUN only. EX_br_taken=1 gives flush_if_id=1 and bubble_ex=1 in the same cycle.
  - Flush has priority over load-use: stall_if=stall_id=0 in that cycle.
- Multi-cycle issue, RUN:
  - Trigger: ID_vld, ID_alu_func is a DIV-class code with DIV_LAT>1 (or MUL-class with MUL_LAT>1), and no load-use or flush this cycle.
  - The instruction issues to EX at the edge. Same edge: state <= MC_BUSY, counter <= LAT-1.
  - LAT==1 means no busy state.
- MC_BUSY (counter != 0):
  - Outputs: stall_if=stall_id=hold_ex=bubble_mem=mc_busy=1; bubble_ex=0; flush_if_id=0.
  - Counter decrements each cycle.
  - Exit: the edge where the counter goes 1->0 sets state <= RUN. Total EX occupancy = LAT cycles; the result leaves EX in the first RUN cycle.
  - EX_br_taken is ignored in MC_BUSY, since the EX instruction is the divide.
- Back-to-back multi-cycle ops re-enter MC_BUSY from RUN after one RUN cycle (the issue cycle of the second op).
- stall_cycles increments on every cycle with stall_if=1 and wraps modulo 2^CNT_W.
- A reset asserted mid-MC_BUSY aborts the op: RUN and counter 0 on the next edge.
- Illegal alu_func values are treated as single-cycle.

Decomposition:
- Shared package: ALU_* function codes, ZERO_REG=6'h00, state enum {RUN, MC_BUSY}.
- Add two package functions: is_div_class(alu_func) and is_mul_class(alu_func).
- Sub-module mc_counter: loadable down-counter, width $clog2(max(DIV_LAT,MUL_LAT)), with load, dec and zero flag.

Test Plan:
1. LW x5 in EX (ID_EX_rd=6'h05, is_load=1) with ADD x6,x5,x1 in ID → stall_if=stall_id=bubble_ex=1 for exactly 1 cycle; stall_cycles=1.
2. FLW f3 in EX (rd=6'h23) with ID_rs2=6'h03 → no stall (bank differs). Same case with ID_rs2=6'h23 → 1-cycle stall.
3. Load to x0 (rd=6'h00) with ID_rs1=6'h00 → no stall.
4. DIV issued with DIV_LAT=32 → mc_busy=1 for 31 cycles after issue, hold_ex=1 throughout; RUN on cycle 32; stall_cycles=31.
5. Load-use condition and EX_br_taken=1 in the same cycle → flush_if_id=1, bubble_ex=1, stall_if=0.
6. rst=1 on the 10th MC_BUSY cycle → next cycle mc_busy=0, all outputs 0, stall_cycles=0; a following DIV gives the full 31-cycle busy period.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: ALU function codes,
// the register-address encoding of the zero register, the sequencer state
// type and the helpers that classify multi-cycle ALU functions.
package pipe_hazard_ctrl_pkg;

  // ALU function codes shared with decode and the EX stage.
  localparam logic [4:0] ALU_ADD    = 5'h00;
  localparam logic [4:0] ALU_SUB    = 5'h01;
  localparam logic [4:0] ALU_SLL    = 5'h02;
  localparam logic [4:0] ALU_SLT    = 5'h03;
  localparam logic [4:0] ALU_SLTU   = 5'h04;
  localparam logic [4:0] ALU_XOR    = 5'h05;
  localparam logic [4:0] ALU_SRL    = 5'h06;
  localparam logic [4:0] ALU_SRA    = 5'h07;
  localparam logic [4:0] ALU_OR     = 5'h08;
  localparam logic [4:0] ALU_AND    = 5'h09;
  localparam logic [4:0] ALU_MUL    = 5'h0A;
  localparam logic [4:0] ALU_MULH   = 5'h0B;
  localparam logic [4:0] ALU_MULHSU = 5'h0C;
  localparam logic [4:0] ALU_MULHU  = 5'h0D;
  localparam logic [4:0] ALU_DIV    = 5'h0E;
  localparam logic [4:0] ALU_DIVU   = 5'h0F;
  localparam logic [4:0] ALU_REM    = 5'h10;
  localparam logic [4:0] ALU_REMU   = 5'h11;
  // Codes 5'h12..5'h1F are unassigned and execute as single-cycle ops.

  // {fp_bank, idx}: only 6'h00 is the hard-wired zero; 6'h20 is f0.
  localparam logic [5:0] ZERO_REG = 6'h00;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  function automatic logic is_div_class(input logic [4:0] alu_func);
    return alu_func inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_mul_class(input logic [4:0] alu_func);
    return alu_func inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mc_counter.sv
// Loadable down-counter tracking the remaining EX occupancy of a
// multi-cycle MUL/DIV. Saturates at zero so a stray dec cannot wrap.
module mc_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Count register: reset clears, load wins over decrement.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Resolves load-use hazards
// with a one-cycle bubble, flushes IF/ID on taken branches, and freezes the
// front end while a multi-cycle MUL/DIV occupies EX.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 32,
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_vld,
  input  logic [5:0]       ID_rs1,
  input  logic [5:0]       ID_rs2,
  input  logic [4:0]       ID_alu_func,
  input  logic [5:0]       ID_EX_rd,
  input  logic             ID_EX_is_load,
  input  logic             ID_EX_vld,
  input  logic             EX_br_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             hold_ex,
  output logic             bubble_mem,
  output logic             flush_if_id,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MAX_LAT = max_int(DIV_LAT, MUL_LAT);
  // The counter holds LAT-1 at most, so $clog2(LAT) bits are enough.
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic          DIV_MC   = (DIV_LAT > 1);
  localparam logic          MUL_MC   = (MUL_LAT > 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);

  state_t        state;
  state_t        state_nxt;
  logic          in_run;
  logic          load_use;
  logic          flush;
  logic          id_div;
  logic          id_mul;
  logic          mc_issue;
  logic [CW-1:0] cnt;
  logic          cnt_zero;

  // Hazard detection: only meaningful while the front end is running.
  assign in_run   = !rst && (state == RUN);
  assign load_use = in_run && ID_vld && ID_EX_vld && ID_EX_is_load &&
                    (ID_EX_rd != ZERO_REG) &&
                    ((ID_rs1 == ID_EX_rd) || (ID_rs2 == ID_EX_rd));
  assign flush    = in_run && EX_br_taken;
  assign id_div   = is_div_class(ID_alu_func);
  assign id_mul   = is_mul_class(ID_alu_func);
  // A multi-cycle op only issues if it actually moves into EX this edge.
  assign mc_issue = in_run && ID_vld && !load_use && !flush &&
                    ((id_div && DIV_MC) || (id_mul && MUL_MC));

  mc_counter #(
    .W (CW)
  ) u_mc_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (mc_issue),
    .load_val (id_div ? DIV_LOAD : MUL_LOAD),
    .dec      (state == MC_BUSY),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: enter MC_BUSY on issue, leave on the edge the counter hits 0.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (mc_issue) state_nxt = MC_BUSY;
      MC_BUSY: if (cnt_zero || (cnt == CW'(1))) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Output decode; every control is forced low while rst is asserted.
  // NOTE: defaulting every output first keeps this block free of latches.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    hold_ex     = 1'b0;
    bubble_mem  = 1'b0;
    flush_if_id = 1'b0;
    mc_busy     = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          // Flush outranks load-use: the stalled instruction is discarded.
          flush_if_id = flush;
          bubble_ex   = flush || load_use;
          stall_if    = load_use && !flush;
          stall_id    = load_use && !flush;
        end
        MC_BUSY: begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          hold_ex    = 1'b1;
          bubble_mem = 1'b1;
          mc_busy    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Performance counter of front-end stall cycles, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_if) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
